// File: rtl/bsg_acm_pkg.sv
// Shared types for the ACM core sharing logic.
// Contents:
//   bsg_acm_arb_state_e : job arbiter state (IDLE, SEND, RECV)
//   max_int             : elaboration-time helper for counter sizing
package bsg_acm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } bsg_acm_arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_acm_rr_pick.sv
// Combinational round-robin picker. The search starts at last_i+1 and wraps,
// so the most recently served requester has the lowest priority.
// Ports:
//   req_i      : request vector, one bit per requester
//   last_i     : index of the most recently served requester
//   grant_oh_o : one-hot grant (all zero when there is no request)
//   grant_id_o : index of the granted requester
//   any_o      : at least one request is present
module bsg_acm_rr_pick #(
  parameter  int num_p = 4,
  localparam int id_w  = $clog2(num_p)
) (
  input  logic [num_p-1:0] req_i,
  input  logic [id_w-1:0]  last_i,
  output logic [num_p-1:0] grant_oh_o,
  output logic [id_w-1:0]  grant_id_o,
  output logic             any_o
);

  logic            found;
  logic [id_w-1:0] idx;

  assign any_o = |req_i;

  always_comb begin
    grant_oh_o = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = '0;
    // i runs 1..num_p so last_i itself is visited last
    for (int i = 1; i <= num_p; i++) begin
      idx = id_w'((int'(last_i) + i) % num_p);
      if (!found && req_i[idx]) begin
        found           = 1'b1;
        grant_oh_o[idx] = 1'b1;
        grant_id_o      = idx;
      end
    end
  end

endmodule

// File: rtl/bsg_acm_client_arbiter.sv
// Shares one ACM encryptor core between num_clients_p requesters. A granted
// client owns the core for a whole job: in_words_p words in, out_words_p words
// out, then arbitration moves on round-robin. Data/valid/ready/yumi paths are
// combinational; only state, counter and grant are registered.
// Ports:
//   clk_i, reset_i         : clock, async active-high reset
//   cl_data_i/cl_v_i       : per-client input words and valids
//   cl_ready_o             : per-client input ready
//   cl_data_o/cl_v_o       : shared result word, per-client result valid
//   cl_yumi_i              : per-client result consume
//   core_data_o/core_v_o   : word/valid to the core, core_ready_i back
//   core_data_i/core_v_i   : result from the core, core_yumi_o back
//   busy_o                 : a job is in flight
//   grant_id_o             : current or last granted client
//
// state | meaning
// IDLE  | no job; pick next requester after last_q
// SEND  | forwarding the granted client's words to the core
// RECV  | routing core results back to the granted client
module bsg_acm_client_arbiter
  import bsg_acm_pkg::*;
#(
  parameter  int num_clients_p = 4,
  parameter  int in_words_p    = 2,
  parameter  int out_words_p   = 1,
  localparam int id_w          = $clog2(num_clients_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [num_clients_p-1:0][63:0]  cl_data_i,
  input  logic [num_clients_p-1:0]        cl_v_i,
  output logic [num_clients_p-1:0]        cl_ready_o,
  output logic [63:0]                     cl_data_o,
  output logic [num_clients_p-1:0]        cl_v_o,
  input  logic [num_clients_p-1:0]        cl_yumi_i,
  output logic [63:0]                     core_data_o,
  output logic                            core_v_o,
  input  logic                            core_ready_i,
  input  logic [63:0]                     core_data_i,
  input  logic                            core_v_i,
  output logic                            core_yumi_o,
  output logic                            busy_o,
  output logic [id_w-1:0]                 grant_id_o
);

  localparam int cnt_w = $clog2(max_int(in_words_p, out_words_p) + 1);
  localparam logic [cnt_w-1:0] in_last_lp  = cnt_w'(in_words_p - 1);
  localparam logic [cnt_w-1:0] out_last_lp = cnt_w'(out_words_p - 1);

  bsg_acm_arb_state_e         state_q;
  logic [cnt_w-1:0]           cnt_q;
  logic [id_w-1:0]            grant_q;
  logic [num_clients_p-1:0]   grant_oh_q;
  logic [id_w-1:0]            last_q;

  logic [num_clients_p-1:0]   pick_oh;
  logic [id_w-1:0]            pick_id;
  logic                       pick_any;
  logic                       in_send;
  logic                       in_recv;

  bsg_acm_rr_pick #(.num_p(num_clients_p)) u_pick (
    .req_i      (cl_v_i),
    .last_i     (last_q),
    .grant_oh_o (pick_oh),
    .grant_id_o (pick_id),
    .any_o      (pick_any)
  );

  assign in_send = (state_q == SEND);
  assign in_recv = (state_q == RECV);

  // Muxes follow grant_q even when idle, so reset presents client 0's word.
  assign core_data_o = cl_data_i[grant_q];
  assign core_v_o    = in_send & cl_v_i[grant_q];
  assign cl_ready_o  = grant_oh_q & {num_clients_p{in_send & core_ready_i}};
  assign cl_data_o   = core_data_i;
  assign cl_v_o      = grant_oh_q & {num_clients_p{in_recv & core_v_i}};
  // Yumi from non-granted clients is masked by the one-hot grant.
  assign core_yumi_o = in_recv & core_v_i & (|(cl_yumi_i & grant_oh_q));
  assign busy_o      = (state_q != IDLE);
  assign grant_id_o  = grant_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_oh_q <= num_clients_p'(1);
      last_q     <= id_w'(num_clients_p - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_id;
            grant_oh_q <= pick_oh;
            cnt_q      <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (core_v_o && core_ready_i) begin
            if (cnt_q == in_last_lp) begin
              cnt_q   <= '0;
              state_q <= RECV;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        RECV: begin
          if (core_yumi_o) begin
            if (cnt_q == out_last_lp) begin
              cnt_q   <= '0;
              last_q  <= grant_q;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_acm_client_arbiter.sv
module tb_bsg_acm_client_arbiter;

  logic              clk_i;
  logic              reset_i;
  logic [3:0][63:0]  cl_data;
  logic [63:0]       core_data_in;

  // default-parameter instance
  logic [3:0]  v0, y0, rdy0, clv0;
  logic        cr0, cv0, corev0, coreyumi0, busy0;
  logic [63:0] cl_dout0, core_dout0;
  logic [1:0]  gid0;

  // in_words_p=1, out_words_p=3 instance
  logic [3:0]  v1, y1, rdy1, clv1;
  logic        cr1, cv1, corev1, coreyumi1, busy1;
  logic [63:0] cl_dout1, core_dout1;
  logic [1:0]  gid1;

  int checks = 0;
  int errors = 0;

  bsg_acm_client_arbiter dut0 (
    .clk_i(clk_i), .reset_i(reset_i),
    .cl_data_i(cl_data), .cl_v_i(v0), .cl_ready_o(rdy0),
    .cl_data_o(cl_dout0), .cl_v_o(clv0), .cl_yumi_i(y0),
    .core_data_o(core_dout0), .core_v_o(corev0), .core_ready_i(cr0),
    .core_data_i(core_data_in), .core_v_i(cv0), .core_yumi_o(coreyumi0),
    .busy_o(busy0), .grant_id_o(gid0)
  );

  bsg_acm_client_arbiter #(.num_clients_p(4), .in_words_p(1), .out_words_p(3)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i),
    .cl_data_i(cl_data), .cl_v_i(v1), .cl_ready_o(rdy1),
    .cl_data_o(cl_dout1), .cl_v_o(clv1), .cl_yumi_i(y1),
    .core_data_o(core_dout1), .core_v_o(corev1), .core_ready_i(cr1),
    .core_data_i(core_data_in), .core_v_i(cv1), .core_yumi_o(coreyumi1),
    .busy_o(busy1), .grant_id_o(gid1)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  yumi;
    logic        cready;
    logic        cvi;
    logic [63:0] word;
    logic [3:0]  e_ready;
    logic [3:0]  e_clv;
    logic        e_corev;
    logic        e_coreyumi;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic [7:0]  e_dsel;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] yumi,
                              input logic cready, input logic cvi,
                              input logic [63:0] word, input logic [3:0] e_ready,
                              input logic [3:0] e_clv, input logic e_corev,
                              input logic e_coreyumi, input logic e_busy,
                              input logic [1:0] e_gid, input logic [7:0] e_dsel);
    vec_t r;
    r.v = v; r.yumi = yumi; r.cready = cready; r.cvi = cvi; r.word = word;
    r.e_ready = e_ready; r.e_clv = e_clv; r.e_corev = e_corev;
    r.e_coreyumi = e_coreyumi; r.e_busy = e_busy; r.e_gid = e_gid; r.e_dsel = e_dsel;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // every client presents the same word, tagged with its index in the top byte
  task automatic drive_words(input logic [63:0] w);
    for (int c = 0; c < 4; c++) cl_data[c] = {8'(c), w[55:0]};
  endtask

  localparam logic [63:0] WA = 64'h00AA_AAAA_0000_0001;
  localparam logic [63:0] WB = 64'h00BB_BBBB_0000_0002;
  localparam logic [63:0] WC = 64'h00CC_CCCC_0000_0003;
  localparam logic [63:0] WD = 64'h00DD_DDDD_0000_0004;
  localparam logic [63:0] RES = 64'hFEED_F00D_1234_5678;

  logic [1:0] rec [5];
  int         nrec;
  logic       prev_busy;
  logic [1:0] fair_exp [5];

  initial begin
    // single client 2: A, B then result
    tbl[0]  = mk(4'h0, 4'h0, 1'b0, 1'b0, WA, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    tbl[1]  = mk(4'h4, 4'h0, 1'b1, 1'b0, WA, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    tbl[2]  = mk(4'h4, 4'h0, 1'b1, 1'b0, WA, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, 8'd2);
    tbl[3]  = mk(4'h4, 4'h0, 1'b1, 1'b0, WB, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, 8'd2);
    tbl[4]  = mk(4'h0, 4'h4, 1'b0, 1'b1, WB, 4'h0, 4'h4, 1'b0, 1'b1, 1'b1, 2'd2, 8'd2);
    tbl[5]  = mk(4'h0, 4'h0, 1'b0, 1'b0, WB, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2);
    // client 1 with core_ready 1,0,1
    tbl[6]  = mk(4'h2, 4'h0, 1'b1, 1'b0, WC, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2);
    tbl[7]  = mk(4'h2, 4'h0, 1'b1, 1'b0, WC, 4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd1);
    tbl[8]  = mk(4'h2, 4'h0, 1'b0, 1'b0, WD, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd1);
    tbl[9]  = mk(4'h2, 4'h0, 1'b1, 1'b0, WD, 4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 8'd1);
    // result stall with foreign yumi from client 3
    for (int i = 10; i < 15; i++)
      tbl[i] = mk(4'h0, 4'h8, 1'b0, 1'b1, WD, 4'h0, 4'h2, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1);
    // granted yumi without core valid is ignored
    tbl[15] = mk(4'h0, 4'h2, 1'b0, 1'b0, WD, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1);
    tbl[16] = mk(4'h0, 4'h2, 1'b0, 1'b1, WD, 4'h0, 4'h2, 1'b0, 1'b1, 1'b1, 2'd1, 8'd1);
    tbl[17] = mk(4'h0, 4'h0, 1'b0, 1'b0, WD, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1);

    fair_exp[0] = 2'd0; fair_exp[1] = 2'd1; fair_exp[2] = 2'd2;
    fair_exp[3] = 2'd3; fair_exp[4] = 2'd0;

    reset_i = 1'b1;
    v0 = '0; y0 = '0; cr0 = 1'b0; cv0 = 1'b0;
    v1 = '0; y1 = '0; cr1 = 1'b0; cv1 = 1'b0;
    core_data_in = RES;
    drive_words(WA);
    #12;
    chk("reset_busy", {63'd0, busy0}, 64'd0);
    chk("reset_core_data", core_dout0, {8'd0, WA[55:0]});
    reset_i = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      @(posedge clk_i); #1;
      v0 = tbl[i].v; y0 = tbl[i].yumi; cr0 = tbl[i].cready; cv0 = tbl[i].cvi;
      drive_words(tbl[i].word);
      #2;
      chk($sformatf("v%0d_cl_ready", i), {60'd0, rdy0}, {60'd0, tbl[i].e_ready});
      chk($sformatf("v%0d_cl_v", i), {60'd0, clv0}, {60'd0, tbl[i].e_clv});
      chk($sformatf("v%0d_core_v", i), {63'd0, corev0}, {63'd0, tbl[i].e_corev});
      chk($sformatf("v%0d_core_yumi", i), {63'd0, coreyumi0}, {63'd0, tbl[i].e_coreyumi});
      chk($sformatf("v%0d_busy", i), {63'd0, busy0}, {63'd0, tbl[i].e_busy});
      chk($sformatf("v%0d_grant_id", i), {62'd0, gid0}, {62'd0, tbl[i].e_gid});
      chk($sformatf("v%0d_core_data", i), core_dout0, {tbl[i].e_dsel, tbl[i].word[55:0]});
      chk($sformatf("v%0d_cl_data", i), cl_dout0, RES);
    end

    // ---------------- reset mid-SEND ----------------
    @(posedge clk_i); #1;
    v0 = 4'h8; cr0 = 1'b1; y0 = '0; cv0 = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_pre_busy", {63'd0, busy0}, 64'd1);
    chk("rst_pre_gid", {62'd0, gid0}, 64'd3);
    @(posedge clk_i); #1;
    chk("rst_mid_core_v", {63'd0, corev0}, 64'd1);
    #1 reset_i = 1'b1;
    #1;
    chk("rst_async_busy", {63'd0, busy0}, 64'd0);
    chk("rst_async_core_v", {63'd0, corev0}, 64'd0);
    chk("rst_async_ready", {60'd0, rdy0}, 64'd0);
    chk("rst_async_gid", {62'd0, gid0}, 64'd0);

    // ---------------- fairness from reset ----------------
    v0 = 4'hF; y0 = 4'hF; cr0 = 1'b1; cv0 = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    nrec = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 40 && nrec < 5; c++) begin
      @(posedge clk_i); #2;
      if (busy0 && !prev_busy) begin
        rec[nrec] = gid0;
        nrec++;
      end
      prev_busy = busy0;
    end
    chk("fair_jobs_seen", 64'(nrec), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < nrec) chk($sformatf("fair_grant%0d", k), {62'd0, rec[k]}, {62'd0, fair_exp[k]});
    v0 = '0; y0 = '0; cr0 = 1'b0; cv0 = 1'b0;

    // ---------------- in_words_p=1, out_words_p=3 ----------------
    @(posedge clk_i); #1;
    v1 = 4'h1; cr1 = 1'b1; cv1 = 1'b1; y1 = 4'h1;
    #1 chk("p_c0_busy", {63'd0, busy1}, 64'd0);
    @(posedge clk_i); #2;
    chk("p_c1_busy", {63'd0, busy1}, 64'd1);
    chk("p_c1_core_v", {63'd0, corev1}, 64'd1);
    chk("p_c1_gid", {62'd0, gid1}, 64'd0);
    @(posedge clk_i); #2;
    chk("p_c2_cl_v", {60'd0, clv1}, 64'd1);
    chk("p_c2_yumi", {63'd0, coreyumi1}, 64'd1);
    @(posedge clk_i); #2;
    chk("p_c3_busy", {63'd0, busy1}, 64'd1);
    chk("p_c3_yumi", {63'd0, coreyumi1}, 64'd1);
    v1 = 4'h3;
    @(posedge clk_i); #2;
    chk("p_c4_busy", {63'd0, busy1}, 64'd1);
    chk("p_c4_yumi", {63'd0, coreyumi1}, 64'd1);
    @(posedge clk_i); #2;
    chk("p_bubble_busy", {63'd0, busy1}, 64'd0);
    chk("p_bubble_cl_v", {60'd0, clv1}, 64'd0);
    chk("p_bubble_yumi", {63'd0, coreyumi1}, 64'd0);
    @(posedge clk_i); #2;
    chk("p_next_busy", {63'd0, busy1}, 64'd1);
    chk("p_next_gid", {62'd0, gid1}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_acm_client_arbiter.md
# bsg_acm_client_arbiter

Round-robin scheduler that lets `num_clients_p` independent requesters share a single ACM encryptor core. It grants one client at a time for a complete job: `in_words_p` input words forwarded to the core, then `out_words_p` result words routed back to the same client. It then re-arbitrates. The block sits between the client-facing channels and the core's 64-bit valid/ready input and valid/yumi output ports, with at most one job in flight.

## Interface
Parameters:
- `num_clients_p`, default 4: number of requesters, ≥2.
- `in_words_p`, default 2: 64-bit words per job entering the core, ≥1.
- `out_words_p`, default 1: 64-bit words per job leaving the core, ≥1.

Ports:
- `clk_i`  in  1  single clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `cl_data_i`  in  `num_clients_p`×64  per-client input word.
- `cl_v_i`  in  `num_clients_p`  per-client input valid.
- `cl_ready_o`  out  `num_clients_p`  per-client input ready.
- `cl_data_o`  out  64  result word, shared by all clients and qualified by `cl_v_o`.
- `cl_v_o`  out  `num_clients_p`  per-client result valid; one-hot or zero.
- `cl_yumi_i`  in  `num_clients_p`  per-client result consume.
- `core_data_o`  out  64  word to the core.
- `core_v_o`  out  1  valid to the core.
- `core_ready_i`  in  1  core input ready.
- `core_data_i`  in  64  core result word.
- `core_v_i`  in  1  core result valid.
- `core_yumi_o`  out  1  consume of the core result.
- `busy_o`  out  1  a job is granted and not yet complete.
- `grant_id_o`  out  `clog2(num_clients_p)`  index of the current or last granted client.

## Operation
- States are IDLE, SEND and RECV.
- **IDLE**
  - All `cl_ready_o`, `cl_v_o`, `core_v_o` and `core_yumi_o` are 0.
  - If any `cl_v_i` is set, pick the first requester searching from `last_q+1` upward with wrap. Register it in `grant_q`, clear `cnt_q` and go to SEND.
- **SEND**
  - `core_data_o` = `cl_data_i[grant_q]`.
  - `core_v_o` = `cl_v_i[grant_q]`.
  - `cl_ready_o[grant_q]` = `core_ready_i`; all other ready bits are 0.
  - Each cycle with `core_v_o & core_ready_i` increments `cnt_q`.
  - On the handshake that makes the count reach `in_words_p`, clear `cnt_q` and go to RECV.
- **RECV**
  - `cl_data_o` = `core_data_i`.
  - `cl_v_o[grant_q]` = `core_v_i`.
  - `core_yumi_o` = `cl_yumi_i[grant_q] & core_v_i`.
  - Each `core_yumi_o` increments `cnt_q`.
  - On the yumi that makes the count reach `out_words_p`, set `last_q` to `grant_q` and go to IDLE.
- `cl_yumi_i` from a non-granted client, or asserted while `core_v_i`=0, is ignored.
- A granted client that deasserts `cl_v_i` mid-job stalls the job; the grant is kept. There is no timeout or preemption.
- Requests that appear during SEND or RECV wait; they never cause starvation because of the rotating start point.
- `cnt_q` width is `clog2(max(in_words_p,out_words_p)+1)`. The count compares exactly and never wraps.
- `busy_o` = (state != IDLE).
- `grant_id_o` = `grant_q`.

## Timing
- Reset values: state IDLE, `cnt_q`=0, `grant_q`=0, `last_q`=`num_clients_p-1` so client 0 has first priority.
  - All outputs are 0 except the data buses, which follow their muxes: `cl_data_o` follows `core_data_i`, and `core_data_o` follows `cl_data_i[0]`.
- Arbitration takes 1 cycle: a request seen in IDLE at cycle t allows the first core handshake at t+1.
- All data, valid, ready and yumi paths in SEND and RECV are combinational pass-through with zero added latency. Only state, counters and grant are registered.
- Back-to-back jobs take one IDLE bubble cycle between the last result yumi and the next grant.
- `in_words_p`=1 or `out_words_p`=1: a single handshake moves SEND to RECV, or RECV to IDLE.
- Reset asserted mid-job aborts it immediately and asynchronously. The core must be reset in the same cycle; the partial job is lost with no replay.

## Structure
- `bsg_acm_pkg` holds the state enum `bsg_acm_arb_state_e` {IDLE, SEND, RECV}.
- Sub-module `bsg_acm_rr_pick` is combinational:
  - inputs: request vector and `last_q`.
  - outputs: one-hot grant, grant index, and an any-request flag.
  - It is reusable by other ACM sharing points.
- The top level holds the FSM, the counter and the muxes.

## Test plan
- **Single client, defaults:** client 2 presents words A,B; core ready held at 1 and returns R.
  - Required: A and B on `core_data_o` on 2 consecutive cycles starting 1 cycle after the request.
  - Then `cl_v_o`=4'b0100 with `cl_data_o`=R. After yumi, `busy_o` falls the next cycle.
- **Fairness:** all 4 clients request continuously.
  - Required: grant order is 0,1,2,3,0 and `grant_id_o` is observed in that order.
- **Backpressure:** `core_ready_i` toggles 1,0,1.
  - Required: exactly 2 input handshakes, no skipped or duplicated word, and `cl_ready_o` mirrors `core_ready_i` for the granted client only.
- **Result stall:** `core_v_i`=1 while the client holds `cl_yumi_i`=0 for 5 cycles, and a non-granted client asserts yumi during that time.
  - Required: `core_yumi_o` stays 0 and the state stays RECV until the granted client's yumi arrives.
- **Reset mid-SEND:** assert `reset_i` after one of two words.
  - Required: outputs clear asynchronously and the next job grants client 0 first.
- **Parameter corners:** `in_words_p`=1, `out_words_p`=3.
  - Required: RECV exits only after the third yumi, and the IDLE bubble is exactly 1 cycle.
